// File: rtl/cdma_pkg.sv
// Shared defaults and FSM state encoding for the 4-user CDMA transmit scheduler.
package cdma_pkg;
  localparam int N_USERS_DEF       = 4;
  localparam int DATA_W_DEF        = 4;
  localparam int CHIPS_PER_BIT_DEF = 4;
  localparam int TIMEOUT_DEF       = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATHER = 2'd1,
    ST_LOAD   = 2'd2,
    ST_SPREAD = 2'd3
  } state_t;
endpackage

// File: rtl/cdma_chip_counter.sv
// Nested chip/bit counter that walks one frame of DATA_W bits x CHIPS_PER_BIT chips.
module cdma_chip_counter
  import cdma_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int CHIPS_PER_BIT = CHIPS_PER_BIT_DEF,
  localparam int BW = $clog2(DATA_W),
  localparam int CW = $clog2(CHIPS_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [BW-1:0] o_bit_idx,
  output logic [CW-1:0] o_chip_idx,
  output logic          o_last
);

  logic [BW-1:0] r_bit;
  logic [CW-1:0] r_chip;
  logic          w_chip_wrap;
  logic          w_bit_wrap;

  assign w_chip_wrap = (r_chip == CW'(CHIPS_PER_BIT - 1));
  assign w_bit_wrap  = (r_bit == BW'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit  <= '0;
      r_chip <= '0;
    end else if (i_clr) begin
      r_bit  <= '0;
      r_chip <= '0;
    end else if (i_en) begin
      if (w_chip_wrap) begin
        r_chip <= '0;
        r_bit  <= w_bit_wrap ? '0 : r_bit + BW'(1);
      end else begin
        r_chip <= r_chip + CW'(1);
      end
    end
  end

  assign o_bit_idx  = r_bit;
  assign o_chip_idx = r_chip;
  assign o_last     = w_chip_wrap & w_bit_wrap;

endmodule

// File: rtl/cdma_tx_scheduler.sv
// Frame scheduler: per-user holding slots, frame alignment FSM with partial-frame timeout,
// and load/spread sequencing for the PISO/spreader datapath.
module cdma_tx_scheduler
  import cdma_pkg::*;
#(
  parameter int N_USERS       = N_USERS_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int CHIPS_PER_BIT = CHIPS_PER_BIT_DEF,
  parameter int TIMEOUT       = TIMEOUT_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_USERS-1:0]                 user_en,
  input  logic [N_USERS-1:0]                 usr_valid,
  input  logic [N_USERS*DATA_W-1:0]          usr_data,
  output logic [N_USERS-1:0]                 usr_ready,
  output logic                               tx_load,
  output logic [N_USERS*DATA_W-1:0]          tx_data,
  output logic [N_USERS-1:0]                 tx_mask,
  output logic [$clog2(DATA_W)-1:0]          bit_idx,
  output logic [$clog2(CHIPS_PER_BIT)-1:0]   chip_idx,
  output logic                               chip_valid,
  output logic                               frame_done,
  output logic                               busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                      r_state;
  logic [TW-1:0]               r_timer;
  logic [N_USERS-1:0]          r_full;
  logic [DATA_W-1:0]           r_slot [N_USERS];
  logic                        r_tx_load;
  logic [N_USERS*DATA_W-1:0]   r_tx_data;
  logic [N_USERS-1:0]          r_tx_mask;

  logic [N_USERS-1:0]          w_want;
  logic [N_USERS-1:0]          w_ready;
  logic [N_USERS*DATA_W-1:0]   w_slot_flat;
  logic                        w_all;
  logic                        w_timeout;
  logic                        w_go_load;
  logic                        w_last;
  logic                        w_spread;

  assign w_want    = r_full & user_en;
  assign w_ready   = ~r_full & user_en & {N_USERS{r_state != ST_LOAD}};
  assign w_all     = (w_want == user_en);
  assign w_timeout = (r_timer == TW'(TIMEOUT - 1));
  assign w_spread  = (r_state == ST_SPREAD);
  assign w_go_load = ((r_state == ST_IDLE) && w_all && (|user_en)) ||
                     ((r_state == ST_GATHER) && (w_all || w_timeout));

  // Slots being framed are released on the edge that enters LOAD; they cannot accept
  // at that edge because they are full, so there is no clear/accept collision.
  for (genvar gi = 0; gi < N_USERS; gi++) begin : g_slot
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_full[gi] <= 1'b0;
        r_slot[gi] <= '0;
      end else if (w_go_load && w_want[gi]) begin
        r_full[gi] <= 1'b0;
      end else if (usr_valid[gi] && w_ready[gi]) begin
        r_full[gi] <= 1'b1;
        r_slot[gi] <= usr_data[gi*DATA_W +: DATA_W];
      end
    end
    assign w_slot_flat[gi*DATA_W +: DATA_W] = r_slot[gi];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_tx_load <= 1'b0;
      r_tx_data <= '0;
      r_tx_mask <= '0;
    end else begin
      r_tx_load <= 1'b0;
      if (w_go_load) begin
        r_state   <= ST_LOAD;
        r_tx_load <= 1'b1;
        r_tx_data <= w_slot_flat;
        r_tx_mask <= w_want;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (|w_want) begin
              r_state <= ST_GATHER;
              r_timer <= '0;
            end
          end
          ST_GATHER: begin
            r_timer <= r_timer + TW'(1);
            if (w_want == '0) r_state <= ST_IDLE;
          end
          ST_LOAD: r_state <= ST_SPREAD;
          ST_SPREAD: begin
            if (w_last) begin
              r_state <= (|w_want) ? ST_GATHER : ST_IDLE;
              r_timer <= '0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  cdma_chip_counter #(
    .DATA_W        (DATA_W),
    .CHIPS_PER_BIT (CHIPS_PER_BIT)
  ) u_chip_counter (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (r_state == ST_LOAD),
    .i_en       (w_spread),
    .o_bit_idx  (bit_idx),
    .o_chip_idx (chip_idx),
    .o_last     (w_last)
  );

  assign usr_ready  = w_ready;
  assign tx_load    = r_tx_load;
  assign tx_data    = r_tx_data;
  assign tx_mask    = r_tx_mask;
  assign chip_valid = w_spread;
  assign frame_done = w_spread & w_last;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cdma_tx_scheduler.sv
// Directed self-checking bench for cdma_tx_scheduler at default parameters.
module tb_cdma_tx_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  user_en;
  logic [3:0]  usr_valid;
  logic [15:0] usr_data;
  logic [3:0]  usr_ready;
  logic        tx_load;
  logic [15:0] tx_data;
  logic [3:0]  tx_mask;
  logic [1:0]  bit_idx;
  logic [1:0]  chip_idx;
  logic        chip_valid;
  logic        frame_done;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  cdma_tx_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .user_en    (user_en),
    .usr_valid  (usr_valid),
    .usr_data   (usr_data),
    .usr_ready  (usr_ready),
    .tx_load    (tx_load),
    .tx_data    (tx_data),
    .tx_mask    (tx_mask),
    .bit_idx    (bit_idx),
    .chip_idx   (chip_idx),
    .chip_valid (chip_valid),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in the first chip cycle; returns one cycle after the last chip.
  task automatic run_spread(input string tag, input bit resend, input logic [15:0] rdata);
    int n;
    int fd_at;
    int idx_bad;
    int overlap;
    n = 0; fd_at = 0; idx_bad = 0; overlap = 0;
    while (chip_valid === 1'b1 && n < 40) begin
      n++;
      if (chip_idx !== 2'((n - 1) % 4) || bit_idx !== 2'((n - 1) / 4)) idx_bad++;
      if (frame_done === 1'b1) begin
        if (fd_at == 0) fd_at = n;
        if (tx_load === 1'b1) overlap++;
      end
      if (resend && n == 3) begin
        chk({tag, "_ready_in_spread"}, {28'd0, usr_ready}, 32'hF);
        usr_valid = 4'hF;
        usr_data  = rdata;
      end else begin
        usr_valid = 4'h0;
      end
      step();
    end
    chk({tag, "_chip_cycles"}, n, 16);
    chk({tag, "_frame_done_at"}, fd_at, 16);
    chk({tag, "_idx_sequence_errs"}, idx_bad, 0);
    chk({tag, "_load_done_overlap"}, overlap, 0);
    chk({tag, "_idx_zero_after"}, {28'd0, bit_idx, chip_idx}, 0);
  endtask

  initial begin
    int n;
    int fd_seen;
    int busy_seen;

    rst = 1'b0; user_en = 4'h0; usr_valid = 4'h0; usr_data = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_load", {31'd0, tx_load}, 0);
    chk("rst_tx_data", {16'd0, tx_data}, 0);
    chk("rst_tx_mask", {28'd0, tx_mask}, 0);
    chk("rst_counters", {28'd0, bit_idx, chip_idx}, 0);
    chk("rst_chip_valid", {31'd0, chip_valid}, 0);
    chk("rst_frame_done", {31'd0, frame_done}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst = 1'b1;
    step();

    // 1: full frame from all four users
    user_en = 4'hF;
    #1;
    chk("t1_ready_idle", {28'd0, usr_ready}, 32'hF);
    usr_valid = 4'hF; usr_data = 16'h3C5A;
    step();
    usr_valid = 4'h0;
    chk("t1_ready_full", {28'd0, usr_ready}, 0);
    chk("t1_no_load_yet", {31'd0, tx_load}, 0);
    step();
    chk("t1_tx_load", {31'd0, tx_load}, 1);
    chk("t1_tx_data", {16'd0, tx_data}, 32'h3C5A);
    chk("t1_tx_mask", {28'd0, tx_mask}, 32'hF);
    chk("t1_ready_load", {28'd0, usr_ready}, 0);
    chk("t1_busy", {31'd0, busy}, 1);
    step();
    chk("t1_first_chip", {31'd0, chip_valid}, 1);
    chk("t1_load_pulse_end", {31'd0, tx_load}, 0);
    run_spread("t1", 1'b0, 16'h0);
    chk("t1_idle_after", {31'd0, busy}, 0);
    chk("t1_data_held", {16'd0, tx_data}, 32'h3C5A);

    // 3: refill during SPREAD, back-to-back frame
    usr_valid = 4'hF; usr_data = 16'h8421;
    step();
    usr_valid = 4'h0;
    step();
    chk("t3_tx_load", {31'd0, tx_load}, 1);
    chk("t3_ready_load", {28'd0, usr_ready}, 0);
    step();
    run_spread("t3a", 1'b1, 16'h1234);
    chk("t3_decision_cycle_load", {31'd0, tx_load}, 0);
    chk("t3_decision_cycle_busy", {31'd0, busy}, 1);
    step();
    chk("t3_b2b_tx_load", {31'd0, tx_load}, 1);
    chk("t3_b2b_tx_data", {16'd0, tx_data}, 32'h1234);
    chk("t3_b2b_tx_mask", {28'd0, tx_mask}, 32'hF);
    step();
    run_spread("t3b", 1'b0, 16'h0);
    chk("t3_idle_after", {31'd0, busy}, 0);

    // 2: single user, partial frame after timeout
    usr_valid = 4'b0100; usr_data = 16'h0700;
    step();
    usr_valid = 4'h0;
    step();
    n = 1;
    chk("t2_gather_busy", {31'd0, busy}, 1);
    while (tx_load !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("t2_cycles_to_load", n, 17);
    chk("t2_tx_mask", {28'd0, tx_mask}, 32'h4);
    chk("t2_tx_data_lane2", {28'd0, tx_data[11:8]}, 32'h7);
    step();
    run_spread("t2", 1'b0, 16'h0);
    chk("t2_idle_after", {31'd0, busy}, 0);

    // 4: users 2/3 disabled
    user_en = 4'b0011;
    #1;
    chk("t4_ready_mask", {28'd0, usr_ready}, 32'h3);
    usr_valid = 4'hF; usr_data = 16'h9876;
    step();
    chk("t4_ready_after", {28'd0, usr_ready}, 0);
    step();
    usr_valid = 4'h0;
    chk("t4_tx_load", {31'd0, tx_load}, 1);
    chk("t4_tx_mask", {28'd0, tx_mask}, 32'h3);
    chk("t4_tx_data_low", {24'd0, tx_data[7:0]}, 32'h76);
    step();
    run_spread("t4", 1'b0, 16'h0);
    chk("t4_idle_after", {31'd0, busy}, 0);

    // 5: reset in the middle of a frame
    user_en = 4'hF;
    usr_valid = 4'hF; usr_data = 16'h5555;
    step();
    usr_valid = 4'h0;
    step();
    step();
    repeat (7) step();
    chk("t5_chip7_idx", {28'd0, bit_idx, chip_idx}, 32'h7);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_rst_tx_data", {16'd0, tx_data}, 0);
    chk("t5_rst_tx_mask", {28'd0, tx_mask}, 0);
    chk("t5_rst_counters", {28'd0, bit_idx, chip_idx}, 0);
    chk("t5_rst_chip_valid", {31'd0, chip_valid}, 0);
    chk("t5_rst_busy", {31'd0, busy}, 0);
    fd_seen = 0;
    repeat (12) begin
      step();
      if (frame_done === 1'b1 || tx_load === 1'b1) fd_seen++;
    end
    chk("t5_no_activity_in_reset", fd_seen, 0);
    rst = 1'b1;
    step();
    chk("t5_idle_after_release", {31'd0, busy}, 0);
    chk("t5_slots_empty", {28'd0, usr_ready}, 32'hF);
    repeat (3) step();
    chk("t5_still_idle", {31'd0, busy}, 0);

    // 6: no users enabled
    user_en = 4'h0;
    usr_valid = 4'hF; usr_data = 16'hFFFF;
    #1;
    chk("t6_ready_zero", {28'd0, usr_ready}, 0);
    busy_seen = 0;
    repeat (30) begin
      step();
      if (busy !== 1'b0) busy_seen++;
    end
    chk("t6_busy_never", busy_seen, 0);
    usr_valid = 4'h0;
    #1;
    user_en = 4'hF;
    step();
    step();
    chk("t6_nothing_captured", {31'd0, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
